// File: rtl/f2h_frame_reader.sv
// Frame reader: streams one frame fetched over Avalon-MM bursts through a credit-guarded FWFT FIFO.
// Optional build macro FRAME_READER_CONT_EN: after the first start_i, frames repeat until rst_i.
module f2h_frame_reader #(
    parameter int unsigned DATA_W      = 256,
    parameter int unsigned ADDR_W      = 27,
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned FRAME_WORDS = 194400,
    parameter int unsigned NUM_BUFS    = 2,
    parameter int unsigned BUF_STRIDE  = 262144,
    parameter int unsigned FIFO_DEPTH  = 256,
    localparam int unsigned SEL_W      = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [SEL_W-1:0]  buf_sel_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [15:0]       frame_count_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic [7:0]        avm_burstcount_o,
    output logic              avm_read_o,
    input  logic              avm_waitrequest_i,
    input  logic [DATA_W-1:0] avm_readdata_i,
    input  logic              avm_readdatavalid_i,
    output logic [DATA_W-1:0] st_data_o,
    output logic              st_valid_o,
    input  logic              st_ready_i,
    output logic              st_sof_o,
    output logic              st_eof_o
);

    localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned FA_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FC_W  = FA_W + 1;
    localparam logic [CNT_W-1:0] FRAME_WORDS_C = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD_C   = CNT_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

    function automatic logic [ADDR_W-1:0] calc_base(input logic [ADDR_W-1:0] base,
                                                    input logic [SEL_W-1:0]  sel);
        logic [SEL_W-1:0] sel_c;
        if (32'(sel) >= NUM_BUFS) sel_c = SEL_W'(NUM_BUFS - 1);
        else                      sel_c = sel;
        return ADDR_W'(64'(base) + 64'(sel_c) * 64'(BUF_STRIDE));
    endfunction

    function automatic logic [7:0] calc_blen(input logic [CNT_W-1:0] issued);
        logic [CNT_W-1:0] left;
        left = FRAME_WORDS_C - issued;
        if (32'(left) < BURST_LEN) return 8'(left);
        else                       return 8'(BURST_LEN);
    endfunction

    // Words already in the FIFO plus words still in flight must leave room for the next burst.
    function automatic logic credit_ok(input logic [FC_W-1:0]  cnt,
                                       input logic [CNT_W-1:0] issued,
                                       input logic [CNT_W-1:0] recv,
                                       input logic [7:0]       blen);
        logic [31:0] need;
        need = 32'(cnt) + 32'(issued - recv) + 32'(blen);
        return (need <= 32'(FIFO_DEPTH));
    endfunction

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  frame_base_q, frame_base_d;
    logic [CNT_W-1:0]   words_issued_q, words_issued_d;
    logic [CNT_W-1:0]   words_recv_q, words_recv_d;
    logic [CNT_W-1:0]   words_out_q, words_out_d;
    logic [FC_W-1:0]    fifo_count_q, fifo_count_d;
    logic [FA_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               avm_read_q, avm_read_d;
    logic [ADDR_W-1:0]  avm_address_q, avm_address_d;
    logic [7:0]         avm_burstcount_q, avm_burstcount_d;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];

    logic               fifo_wr_s, fifo_rd_s, st_valid_s, accept_s, launch_s;
    logic [CNT_W-1:0]   issued_next_s;
    logic [ADDR_W-1:0]  base_s;
    logic [7:0]         blen_s;

    // Next-state, request and FIFO bookkeeping.
    always_comb begin
        fifo_wr_s     = avm_readdatavalid_i && (state_q != IDLE);
        st_valid_s    = (fifo_count_q != {FC_W{1'b0}});
        fifo_rd_s     = st_valid_s && st_ready_i;
        accept_s      = avm_read_q && !avm_waitrequest_i;
        issued_next_s = words_issued_q + (accept_s ? CNT_W'(avm_burstcount_q) : {CNT_W{1'b0}});
        launch_s      = 1'b0;
        base_s        = {ADDR_W{1'b0}};
        blen_s        = 8'd0;

        state_d          = state_q;
        frame_base_d     = frame_base_q;
        words_issued_d   = words_issued_q;
        words_recv_d     = words_recv_q + CNT_W'(fifo_wr_s);
        words_out_d      = words_out_q + CNT_W'(fifo_rd_s);
        fifo_count_d     = fifo_count_q + FC_W'(fifo_wr_s) - FC_W'(fifo_rd_s);
        wr_ptr_d         = wr_ptr_q + FA_W'(fifo_wr_s);
        rd_ptr_d         = rd_ptr_q + FA_W'(fifo_rd_s);
        busy_d           = busy_q;
        frame_done_d     = 1'b0;
        frame_count_d    = frame_count_q;
        avm_read_d       = avm_read_q;
        avm_address_d    = avm_address_q;
        avm_burstcount_d = avm_burstcount_q;

        case (state_q)
            IDLE: begin
                if (start_i) launch_s = 1'b1;
                else         launch_s = 1'b0;
            end
            ISSUE: begin
                if (avm_read_q && avm_waitrequest_i) begin
                    avm_read_d = 1'b1;
                end else if (issued_next_s == FRAME_WORDS_C) begin
                    words_issued_d = issued_next_s;
                    avm_read_d     = 1'b0;
                    state_d        = DRAIN;
                end else begin
                    words_issued_d   = issued_next_s;
                    blen_s           = calc_blen(issued_next_s);
                    avm_address_d    = frame_base_q + ADDR_W'(issued_next_s);
                    avm_burstcount_d = blen_s;
                    avm_read_d       = credit_ok(fifo_count_q, issued_next_s, words_recv_q, blen_s);
                end
            end
            DRAIN: begin
                if (fifo_rd_s && (words_out_q == LAST_WORD_C)) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
`ifdef FRAME_READER_CONT_EN
                    launch_s      = 1'b1;
`else
                    busy_d        = 1'b0;
                    state_d       = IDLE;
`endif
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: latch buffer base and present the first burst on the next cycle.
        if (launch_s) begin
            base_s           = calc_base(base_addr_i, buf_sel_i);
            blen_s           = calc_blen({CNT_W{1'b0}});
            frame_base_d     = base_s;
            words_issued_d   = {CNT_W{1'b0}};
            words_recv_d     = {CNT_W{1'b0}};
            words_out_d      = {CNT_W{1'b0}};
            busy_d           = 1'b1;
            state_d          = ISSUE;
            avm_address_d    = base_s;
            avm_burstcount_d = blen_s;
            avm_read_d       = credit_ok(fifo_count_q, {CNT_W{1'b0}}, {CNT_W{1'b0}}, blen_s);
        end else begin
            base_s = {ADDR_W{1'b0}};
        end
    end

    // Control and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            frame_base_q     <= {ADDR_W{1'b0}};
            words_issued_q   <= {CNT_W{1'b0}};
            words_recv_q     <= {CNT_W{1'b0}};
            words_out_q      <= {CNT_W{1'b0}};
            fifo_count_q     <= {FC_W{1'b0}};
            wr_ptr_q         <= {FA_W{1'b0}};
            rd_ptr_q         <= {FA_W{1'b0}};
            busy_q           <= 1'b0;
            frame_done_q     <= 1'b0;
            frame_count_q    <= 16'd0;
            avm_read_q       <= 1'b0;
            avm_address_q    <= {ADDR_W{1'b0}};
            avm_burstcount_q <= 8'd0;
        end else begin
            state_q          <= state_d;
            frame_base_q     <= frame_base_d;
            words_issued_q   <= words_issued_d;
            words_recv_q     <= words_recv_d;
            words_out_q      <= words_out_d;
            fifo_count_q     <= fifo_count_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            busy_q           <= busy_d;
            frame_done_q     <= frame_done_d;
            frame_count_q    <= frame_count_d;
            avm_read_q       <= avm_read_d;
            avm_address_q    <= avm_address_d;
            avm_burstcount_q <= avm_burstcount_d;
        end
    end

    // FIFO storage; contents need no reset since validity comes from fifo_count_q.
    always_ff @(posedge clk_i) begin
        if (fifo_wr_s && !rst_i) begin
            mem_q[wr_ptr_q] <= avm_readdata_i;
        end
    end

    assign busy_o           = busy_q;
    assign frame_done_o     = frame_done_q;
    assign frame_count_o    = frame_count_q;
    assign avm_read_o       = avm_read_q;
    assign avm_address_o    = avm_address_q;
    assign avm_burstcount_o = avm_burstcount_q;
    assign st_valid_o       = st_valid_s;
    assign st_data_o        = st_valid_s ? mem_q[rd_ptr_q] : {DATA_W{1'b0}};
    assign st_sof_o         = st_valid_s && (words_out_q == {CNT_W{1'b0}});
    assign st_eof_o         = st_valid_s && (words_out_q == LAST_WORD_C);

endmodule

// File: tb/tb_f2h_frame_reader.sv
// Scoreboard bench for f2h_frame_reader: Avalon slave model, stream monitor, directed frame tests.
module tb_f2h_frame_reader;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 27;
    localparam int BURST_LEN   = 64;
    localparam int FRAME_WORDS = 200;
    localparam int NUM_BUFS    = 3;
    localparam int BUF_STRIDE  = 32'h40000;
    localparam int FIFO_DEPTH  = 128;

    logic              clk = 1'b0;
    logic              rst_i, start_i, st_ready_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [1:0]        buf_sel_i;
    logic              busy_o, frame_done_o, avm_read_o;
    logic [15:0]       frame_count_o;
    logic [ADDR_W-1:0] avm_address_o;
    logic [7:0]        avm_burstcount_o;
    logic              avm_waitrequest_i, avm_readdatavalid_i;
    logic [DATA_W-1:0] avm_readdata_i, st_data_o;
    logic              st_valid_o, st_sof_o, st_eof_o;

    f2h_frame_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS),
        .NUM_BUFS(NUM_BUFS), .BUF_STRIDE(BUF_STRIDE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .buf_sel_i(buf_sel_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
        .frame_count_o(frame_count_o), .avm_address_o(avm_address_o),
        .avm_burstcount_o(avm_burstcount_o), .avm_read_o(avm_read_o),
        .avm_waitrequest_i(avm_waitrequest_i), .avm_readdata_i(avm_readdata_i),
        .avm_readdatavalid_i(avm_readdatavalid_i), .st_data_o(st_data_o),
        .st_valid_o(st_valid_o), .st_ready_i(st_ready_i), .st_sof_o(st_sof_o), .st_eof_o(st_eof_o)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [ADDR_W-1:0] addr; logic [7:0] bc; } burst_t;
    typedef struct packed { logic [DATA_W-1:0] data; logic sof; logic eof; } word_t;

    burst_t            exp_bursts[$];
    word_t             exp_words[$];
    logic [DATA_W-1:0] pend[$];
    int                burst_off[4];
    int                burst_cnt[4];

    int     n_cmp = 0, n_bad = 0;
    int     bursts_acc = 0, words_seen = 0, done_cnt = 0, done_target = 0;
    int     occ = 0, max_occ = 0, hold_left = 0, hold_burst_idx = -1;
    logic   expect_done = 1'b0, prev_hold = 1'b0, flush_req = 1'b0;
    word_t  held;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected bursts (hand table of offsets/counts) and stream words for one frame at first_addr.
    task automatic push_frame(input logic [ADDR_W-1:0] first_addr);
        burst_t b;
        word_t  w;
        for (int k = 0; k < 4; k++) begin
            b.addr = first_addr + ADDR_W'(burst_off[k]);
            b.bc   = 8'(burst_cnt[k]);
            exp_bursts.push_back(b);
        end
        for (int i = 0; i < FRAME_WORDS; i++) begin
            w.data = DATA_W'(first_addr + ADDR_W'(i));
            w.sof  = (i == 0);
            w.eof  = (i == FRAME_WORDS - 1);
            exp_words.push_back(w);
        end
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] base, input logic [1:0] sel,
                               input logic [ADDR_W-1:0] first_addr);
        push_frame(first_addr);
        done_target = done_cnt + 1;
        base_addr_i = base;
        buf_sel_i   = sel;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
        @(negedge clk);
        check("first_read", 128'({avm_read_o, avm_address_o, avm_burstcount_o, busy_o}),
              128'({1'b1, first_addr, 8'd64, 1'b1}));
    endtask

    task automatic finish_frame(input logic [15:0] exp_count);
        int cyc = 0;
        while (done_cnt < done_target && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (done_cnt < done_target) fail_now("timeout_frame_done");
        repeat (3) @(negedge clk);
        check("frame_count", 128'(frame_count_o), 128'(exp_count));
        check("idle_after_frame", 128'({busy_o, avm_read_o, st_valid_o}), 128'(0));
        check("queues_drained", 128'({exp_words.size(), exp_bursts.size()}), 128'(0));
    endtask

    task automatic wait_words(input int target);
        int cyc = 0;
        while (words_seen < target && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (words_seen < target) fail_now("timeout_words");
    endtask

    task automatic apply_reset();
        tick();
        rst_i     = 1'b1;
        flush_req = 1'b1;
        exp_words.delete();
        exp_bursts.delete();
        tick();
        @(negedge clk);
        check("outputs_in_reset",
              128'({busy_o, frame_done_o, frame_count_o, avm_read_o, avm_address_o,
                    avm_burstcount_o, st_valid_o, st_sof_o, st_eof_o, st_data_o}), 128'(0));
        tick();
        rst_i = 1'b0;
    endtask

    // Avalon slave: checks accepted bursts, returns data = word address one beat per cycle.
    initial begin
        burst_t b;
        avm_waitrequest_i   = 1'b0;
        avm_readdatavalid_i = 1'b0;
        avm_readdata_i      = '0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (avm_waitrequest_i) begin
                    if (exp_bursts.size() == 0) fail_now("hold_no_expected_burst");
                    else check("wait_hold", 128'({avm_read_o, avm_address_o, avm_burstcount_o}),
                               128'({1'b1, exp_bursts[0]}));
                    hold_left--;
                end else if (avm_read_o) begin
                    if (exp_bursts.size() == 0) begin
                        fail_now("burst_unexpected");
                    end else begin
                        b = exp_bursts.pop_front();
                        check("burst", 128'({avm_address_o, avm_burstcount_o}), 128'(b));
                    end
                    for (int j = 0; j < int'(avm_burstcount_o); j++)
                        pend.push_back(DATA_W'(avm_address_o + ADDR_W'(j)));
                    bursts_acc++;
                end
            end
            @(posedge clk);
            #2;
            if (flush_req) begin
                while (pend.size() > 3) void'(pend.pop_back());
                flush_req = 1'b0;
            end
            if (pend.size() > 0) begin
                avm_readdatavalid_i = 1'b1;
                avm_readdata_i      = pend.pop_front();
            end else begin
                avm_readdatavalid_i = 1'b0;
            end
            avm_waitrequest_i = (hold_left > 0) && (bursts_acc == hold_burst_idx);
        end
    end

    // Stream monitor: pops expected words, checks stall stability and the frame_done pulse.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                expect_done = 1'b0;
                prev_hold   = 1'b0;
                occ         = 0;
            end else begin
                if (frame_done_o || expect_done) check("frame_done", 128'(frame_done_o), 128'(expect_done));
                if (frame_done_o) done_cnt++;
                expect_done = 1'b0;
                if (avm_readdatavalid_i && busy_o) occ++;
                if (prev_hold)
                    check("stall_stable", 128'({st_valid_o, st_data_o, st_sof_o, st_eof_o}),
                          128'({1'b1, held}));
                if (st_valid_o && st_ready_i) begin
                    occ--;
                    words_seen++;
                    if (exp_words.size() == 0) begin
                        fail_now("stream_unexpected");
                    end else begin
                        w = exp_words.pop_front();
                        check("stream_word", 128'({st_data_o, st_sof_o, st_eof_o}), 128'(w));
                    end
                    expect_done = st_eof_o;
                    prev_hold   = 1'b0;
                end else if (st_valid_o) begin
                    prev_hold = 1'b1;
                    held      = {st_data_o, st_sof_o, st_eof_o};
                end else begin
                    prev_hold = 1'b0;
                end
                if (occ > max_occ) max_occ = occ;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int b0;
        burst_off   = '{0, 64, 128, 192};
        burst_cnt   = '{64, 64, 64, 8};
        rst_i       = 1'b1;
        start_i     = 1'b0;
        st_ready_i  = 1'b1;
        base_addr_i = '0;
        buf_sel_i   = 2'd0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_state",
              128'({busy_o, frame_done_o, frame_count_o, avm_read_o, avm_address_o,
                    avm_burstcount_o, st_valid_o, st_sof_o, st_eof_o, st_data_o}), 128'(0));
        tick();
        rst_i = 1'b0;
        repeat (2) tick();

`ifdef FRAME_READER_CONT_EN
        begin
            logic busy_dropped = 1'b0;
            int   cyc = 0;
            start_frame(27'h1000, 2'd0, 27'h1000);
            push_frame(27'h41000);
            push_frame(27'h41000);
            done_target = done_cnt + 2;
            while (done_cnt < done_target && cyc < 4000) begin
                @(negedge clk);
                cyc++;
                if (words_seen >= 50) buf_sel_i = 2'd1;
                if (!busy_o) busy_dropped = 1'b1;
            end
            if (done_cnt < done_target) fail_now("timeout_cont_frames");
            check("cont_busy_held", 128'(busy_dropped), 128'(0));
            check("cont_frame_count", 128'(frame_count_o), 128'(2));
            apply_reset();
        end
`else
        // Burst split with short final burst.
        start_frame(27'h1000, 2'd0, 27'h1000);
        finish_frame(16'd1);

        // Buffer select, and out-of-range select clamped to the last buffer.
        start_frame(27'h100, 2'd1, 27'h40100);
        finish_frame(16'd2);
        start_frame(27'h100, 2'd3, 27'h80100);
        finish_frame(16'd3);

        // Waitrequest held for 5 cycles on the second burst.
        hold_left      = 5;
        hold_burst_idx = bursts_acc + 1;
        start_frame(27'h2000, 2'd0, 27'h2000);
        finish_frame(16'd4);
        check("wait_cycles_used", 128'(hold_left), 128'(0));

        // Credit limit with stream stalled.
        st_ready_i = 1'b0;
        max_occ    = 0;
        b0         = bursts_acc;
        start_frame(27'h3000, 2'd0, 27'h3000);
        repeat (160) @(negedge clk);
        check("credit_bursts", 128'(bursts_acc - b0), 128'(2));
        check("credit_read_low", 128'(avm_read_o), 128'(0));
        check("credit_fifo_full", 128'(max_occ), 128'(FIFO_DEPTH));
        tick();
        st_ready_i = 1'b1;
        finish_frame(16'd5);
        check("fifo_never_over", 128'(max_occ), 128'(FIFO_DEPTH));

        // Reset mid-frame, stale beats ignored, then a clean frame.
        w0 = words_seen;
        start_frame(27'h5000, 2'd0, 27'h5000);
        wait_words(w0 + 100);
        apply_reset();
        repeat (10) tick();
        @(negedge clk);
        check("no_stale_output", 128'({st_valid_o, busy_o}), 128'(0));
        start_frame(27'h6000, 2'd0, 27'h6000);
        finish_frame(16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
